// File: rtl/loader_pkg.sv
// Shared types and constants for the streaming program loader.
// Imported by the loader top level and by its byte-to-word packer.
package loader_pkg;

    // Top-level load sequencing.
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_BYTE,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } loader_state_t;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    // The header is one byte, so 256 words is the largest count and
    // ADDR_W+1 = 9 bits always holds it for the 256-deep memory.
    localparam int CNT_W = BYTE_W + 1;

    // Header byte 0 encodes a full 256-word load.
    function automatic logic [CNT_W-1:0] hdr_to_count(input logic [BYTE_W-1:0] hdr);
        return (hdr == '0) ? CNT_W'(256) : CNT_W'(hdr);
    endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Assembles bytes MSB-first into 32-bit words and keeps a running XOR
// checksum of every payload byte shifted in.
module loader_word_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_full_o,
    output logic [BYTE_W-1:0] chk_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q,  idx_d;
    logic [BYTE_W-1:0] chk_q,  chk_d;

    always_comb begin
        // NOTE: every always_comb target gets a default first; a path that
        // leaves one unassigned would infer a latch.
        word_d = word_q;
        idx_d  = idx_q;
        chk_d  = chk_q;
        if (clear_i) begin
            idx_d = '0;
            chk_d = '0;
        end else if (shift_i) begin
            word_d = {word_q[WORD_W-BYTE_W-1:0], byte_i};
            idx_d  = idx_q + IDX_W'(1);
            chk_d  = chk_q ^ byte_i;
        end
    end

    // Pulses on the handshake that completes a word; the index wraps to 0.
    assign word_full_o = shift_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    assign word_o      = word_q;
    assign chk_o       = chk_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order; the
    // reset here is synchronous, tested inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
            chk_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            chk_q  <= chk_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streaming program loader: header byte N, N words MSB-first, XOR checksum.
// Writes words to consecutive instr_mem addresses and holds the CPU meanwhile.
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;
    logic              s_ready_q, s_ready_d;
    logic              wr_en_q, wr_en_d;

    logic              xfer;
    logic              pk_clear;
    logic              pk_shift;
    logic              pk_word_full;
    logic [WORD_W-1:0] pk_word;
    logic [BYTE_W-1:0] pk_chk;

    assign xfer = s_valid && s_ready_q;

    loader_word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (pk_clear),
        .shift_i     (pk_shift),
        .byte_i      (s_data),
        .word_o      (pk_word),
        .word_full_o (pk_word_full),
        .chk_o       (pk_chk)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        done_d   = done_q;
        err_d    = err_q;
        hold_d   = hold_q;
        pk_clear = 1'b0;
        pk_shift = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d  = S_HDR;
                    cnt_d    = '0;
                    addr_d   = ADDR_W'(START_ADDR);
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    hold_d   = 1'b1;
                    pk_clear = 1'b1;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    cnt_d   = hdr_to_count(s_data);
                    state_d = S_BYTE;
                end
            end
            S_BYTE: begin
                if (xfer) begin
                    pk_shift = 1'b1;
                    if (pk_word_full) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Address wraps mod 2^ADDR_W; loads past the top are legal.
                addr_d  = addr_q + ADDR_W'(1);
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? S_CHK : S_BYTE;
            end
            S_CHK: begin
                if (xfer) begin
                    if (s_data == pk_chk) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes decode the next state so they come straight from flops.
        s_ready_d = (state_d == S_HDR) || (state_d == S_BYTE) || (state_d == S_CHK);
        wr_en_d   = (state_d == S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= ADDR_W'(START_ADDR);
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            hold_q    <= 1'b0;
            s_ready_q <= 1'b0;
            wr_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            err_q     <= err_d;
            hold_q    <= hold_d;
            s_ready_q <= s_ready_d;
            wr_en_q   <= wr_en_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign mem_wr_en = wr_en_q;
    assign mem_addr  = addr_q;
    assign mem_data  = DATA_W'(pk_word);
    assign cpu_hold  = hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
